// File: rtl/updown_timer_gen.sv
// Multi-digit up/down tick timer with prescaler, clamped load, terminal-count pulse and 7-seg decode.
// Optional build macro UPDOWN_TIMER_SATURATE_EN: saturate at the boundary instead of wrapping.
module updown_timer_gen #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 1000,
    parameter int DIGITS    = 5,
    parameter int DIGIT_MOD = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count_o,
    output logic [7*DIGITS-1:0]   seg_o,
    output logic                  tick_o,
    output logic                  tc_o
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]       PMAX    = PW'(DIV - 1);
    localparam logic [3:0]          DMAX    = 4'(DIGIT_MOD - 1);
    localparam logic [4*DIGITS-1:0] ALL_MAX = {DIGITS{DMAX}};

    logic [PW-1:0]       presc;
    logic [4*DIGITS-1:0] cnt;
    logic [4*DIGITS-1:0] stepped;
    logic [4*DIGITS-1:0] next_cnt;
    logic [4*DIGITS-1:0] clamped;
    logic                carry;
    logic                wrap;
    logic                at_bound;
    logic                step_tc;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Ripple carry/borrow through the digit chain, least significant first.
    always_comb begin
        stepped = cnt;
        carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (up) begin
                    if (cnt[4*i +: 4] == DMAX) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (cnt[4*i +: 4] == 4'd0) begin
                        stepped[4*i +: 4] = DMAX;
                    end else begin
                        stepped[4*i +: 4] = cnt[4*i +: 4] - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        wrap     = (presc == PMAX);
        at_bound = up ? (cnt == ALL_MAX) : (cnt == '0);
`ifdef UPDOWN_TIMER_SATURATE_EN
        next_cnt = at_bound ? cnt : stepped;
        step_tc  = !at_bound && (up ? (stepped == ALL_MAX) : (stepped == '0));
`else
        next_cnt = stepped;
        step_tc  = at_bound;
`endif
    end

    always_comb begin
        clamped = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > DMAX) clamped[4*i +: 4] = DMAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc  <= '0;
            cnt    <= '0;
            tick_o <= 1'b0;
            tc_o   <= 1'b0;
        end else if (load) begin
            presc  <= '0;
            cnt    <= clamped;
            tick_o <= 1'b0;
            tc_o   <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                presc  <= '0;
                cnt    <= next_cnt;
                tick_o <= 1'b1;
                tc_o   <= step_tc;
            end else begin
                presc  <= presc + PW'(1);
                tick_o <= 1'b0;
                tc_o   <= 1'b0;
            end
        end else begin
            tick_o <= 1'b0;
            tc_o   <= 1'b0;
        end
    end

    assign count_o = cnt;

    always_comb begin
        seg_o = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg_o[7*i +: 7] = seg7(cnt[4*i +: 4]);
        end
    end

endmodule

// File: tb/tb_updown_timer_gen.sv
// Self-checking bench for updown_timer_gen: DIV=10, two decimal digits, integer-valued reference model.
module tb_updown_timer_gen;

    localparam int CLK_HZ    = 10;
    localparam int TICK_HZ   = 1;
    localparam int DIGITS    = 2;
    localparam int DIGIT_MOD = 10;
    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int N         = DIGIT_MOD ** DIGITS;
`ifdef UPDOWN_TIMER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst, en, up, load;
    logic [4*DIGITS-1:0] load_val;
    logic [4*DIGITS-1:0] count_o;
    logic [7*DIGITS-1:0] seg_o;
    logic                tick_o, tc_o;

    updown_timer_gen #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(DIGITS), .DIGIT_MOD(DIGIT_MOD)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count_o(count_o), .seg_o(seg_o), .tick_o(tick_o), .tc_o(tc_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int   m_presc = 0;
    int   m_val   = 0;
    logic m_tick  = 1'b0;
    logic m_tc    = 1'b0;

    // Active-low {g,f,e,d,c,b,a} glyphs 0-9, A b C d E F
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [4*DIGITS-1:0] to_digits(input int v);
        logic [4*DIGITS-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % DIGIT_MOD);
            t = t / DIGIT_MOD;
        end
        return r;
    endfunction

    function automatic logic [7*DIGITS-1:0] exp_seg(input int v);
        logic [7*DIGITS-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[7*i +: 7] = glyph[t % DIGIT_MOD];
            t = t / DIGIT_MOD;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [4*DIGITS-1:0] lv);
        int v, w, d;
        v = 0;
        w = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d >= DIGIT_MOD) d = DIGIT_MOD - 1;
            v = v + d * w;
            w = w * DIGIT_MOD;
        end
        return v;
    endfunction

    // Reference behaviour for one clock edge, using the inputs currently applied.
    task automatic model_edge();
        m_tick = 1'b0;
        m_tc   = 1'b0;
        if (rst) begin
            m_presc = 0;
            m_val   = 0;
        end else if (load) begin
            m_presc = 0;
            m_val   = clamp_val(load_val);
        end else if (en) begin
            if (m_presc == DIV - 1) begin
                m_presc = 0;
                m_tick  = 1'b1;
                if (up) begin
                    if (m_val == N - 1) begin
                        if (!SAT) begin m_val = 0; m_tc = 1'b1; end
                    end else begin
                        m_val = m_val + 1;
                        if (SAT && m_val == N - 1) m_tc = 1'b1;
                    end
                end else begin
                    if (m_val == 0) begin
                        if (!SAT) begin m_val = N - 1; m_tc = 1'b1; end
                    end else begin
                        m_val = m_val - 1;
                        if (SAT && m_val == 0) m_tc = 1'b1;
                    end
                end
            end else begin
                m_presc = m_presc + 1;
            end
        end
    endtask

    task automatic clk_step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; load_val = 8'h42; en = 1'b1; up = 1'b1;
        repeat (3) clk_step();
        checks++;
        if (count_o !== 8'h00) begin errors++; $display("FAIL reset_count got=%h want=00", count_o); end
        checks++;
        if (seg_o !== 14'h2040) begin errors++; $display("FAIL reset_seg got=%h want=2040", seg_o); end
        checks++;
        if (tick_o !== 1'b0 || tc_o !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got tick=%b tc=%b want 0 0", tick_o, tc_o);
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_up_count();
        int ticks, tcs, first_tick;
        ticks = 0; tcs = 0; first_tick = -1;
        en = 1'b1; up = 1'b1;
        for (int c = 1; c <= 1000; c++) begin
            clk_step();
            checks++;
            if (count_o !== to_digits(m_val) || tick_o !== m_tick || tc_o !== m_tc || seg_o !== exp_seg(m_val)) begin
                errors++;
                $display("FAIL up_cycle c=%0d got count=%h tick=%b tc=%b seg=%h want count=%h tick=%b tc=%b seg=%h",
                         c, count_o, tick_o, tc_o, seg_o, to_digits(m_val), m_tick, m_tc, exp_seg(m_val));
            end
            if (tick_o === 1'b1) begin
                ticks++;
                if (first_tick < 0) first_tick = c;
            end
            if (tc_o === 1'b1) tcs++;
        end
        checks++;
        if (first_tick != 10) begin errors++; $display("FAIL up_first_tick got=%0d want=10", first_tick); end
        checks++;
        if (ticks != 100) begin errors++; $display("FAIL up_tick_count got=%0d want=100", ticks); end
        checks++;
        if (tcs != 1) begin errors++; $display("FAIL up_tc_count got=%0d want=1", tcs); end
        checks++;
        if (count_o !== 8'h00) begin errors++; $display("FAIL up_full_cycle got=%h want=00", count_o); end
    endtask

    task automatic test_down_count();
        int tcs;
        tcs = 0;
        en = 1'b0; load = 1'b1; load_val = 8'h01;
        clk_step();
        load = 1'b0;
        checks++;
        if (count_o !== 8'h01) begin errors++; $display("FAIL down_load got=%h want=01", count_o); end
        en = 1'b1; up = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            clk_step();
            checks++;
            if (count_o !== to_digits(m_val) || tick_o !== m_tick || tc_o !== m_tc) begin
                errors++;
                $display("FAIL down_cycle c=%0d got count=%h tick=%b tc=%b want count=%h tick=%b tc=%b",
                         c, count_o, tick_o, tc_o, to_digits(m_val), m_tick, m_tc);
            end
            if (tc_o === 1'b1) begin
                tcs++;
                checks++;
                if (count_o !== 8'h99) begin errors++; $display("FAIL down_tc_edge got=%h want=99", count_o); end
            end
        end
        checks++;
        if (tcs != 1) begin errors++; $display("FAIL down_tc_count got=%0d want=1", tcs); end
        checks++;
        if (count_o !== 8'h98) begin errors++; $display("FAIL down_final got=%h want=98", count_o); end
    endtask

    task automatic test_load_collision();
        int guard;
        en = 1'b1; up = 1'b1;
        guard = 0;
        while (m_presc != DIV - 1 && guard < 2 * DIV) begin clk_step(); guard++; end
        load = 1'b1; load_val = 8'h57;
        clk_step();
        load = 1'b0;
        checks++;
        if (count_o !== 8'h57 || tick_o !== 1'b0 || tc_o !== 1'b0) begin
            errors++; $display("FAIL collision_load got count=%h tick=%b tc=%b want 57 0 0", count_o, tick_o, tc_o);
        end
        for (int k = 1; k <= DIV; k++) begin
            clk_step();
            checks++;
            if (count_o !== to_digits(m_val) || tick_o !== m_tick || tc_o !== m_tc) begin
                errors++;
                $display("FAIL collision_cycle k=%0d got count=%h tick=%b want count=%h tick=%b",
                         k, count_o, tick_o, to_digits(m_val), m_tick);
            end
        end
        checks++;
        if (count_o !== 8'h58 || tick_o !== 1'b1) begin
            errors++; $display("FAIL collision_next_step got count=%h tick=%b want 58 1", count_o, tick_o);
        end
        load = 1'b1; load_val = 8'h5C;
        clk_step();
        load = 1'b0;
        checks++;
        if (count_o !== 8'h59) begin errors++; $display("FAIL load_clamp got=%h want=59", count_o); end
    endtask

    task automatic test_enable_hold();
        int guard, lat;
        logic [4*DIGITS-1:0] held;
        en = 1'b1; up = 1'b1;
        guard = 0;
        while (m_presc != 4 && guard < 2 * DIV) begin clk_step(); guard++; end
        held = count_o;
        en = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            clk_step();
            checks++;
            if (count_o !== held || tick_o !== 1'b0 || tc_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_frozen k=%0d got count=%h tick=%b want count=%h tick=0", k, count_o, tick_o, held);
            end
        end
        en = 1'b1;
        lat = -1;
        for (int k = 1; k <= 2 * DIV; k++) begin
            clk_step();
            if (tick_o === 1'b1 && lat < 0) lat = k;
            if (lat > 0) break;
        end
        checks++;
        if (lat != 6) begin errors++; $display("FAIL hold_resume_latency got=%0d want=6", lat); end
        checks++;
        if (count_o !== to_digits(m_val)) begin
            errors++; $display("FAIL hold_resume_count got=%h want=%h", count_o, to_digits(m_val));
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            load     = ($urandom_range(0, 49) == 0);
            load_val = 8'($urandom);
            en       = ($urandom_range(0, 9) != 0);
            up       = ($urandom_range(0, 3) != 0) ^ (c >= 1500);
            clk_step();
            checks++;
            if (count_o !== to_digits(m_val) || tick_o !== m_tick || tc_o !== m_tc || seg_o !== exp_seg(m_val)) begin
                errors++;
                $display("FAIL random_cycle c=%0d got count=%h tick=%b tc=%b seg=%h want count=%h tick=%b tc=%b seg=%h",
                         c, count_o, tick_o, tc_o, seg_o, to_digits(m_val), m_tick, m_tc, exp_seg(m_val));
            end
        end
        rst = 1'b0; load = 1'b0;
    endtask

`ifdef UPDOWN_TIMER_SATURATE_EN
    task automatic test_saturate();
        int ticks, tcs;
        en = 1'b0; load = 1'b1; load_val = 8'h98;
        clk_step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        repeat (DIV) clk_step();
        checks++;
        if (count_o !== 8'h99 || tc_o !== 1'b1) begin
            errors++; $display("FAIL sat_reach got count=%h tc=%b want 99 1", count_o, tc_o);
        end
        ticks = 0; tcs = 0;
        for (int k = 0; k < 3 * DIV; k++) begin
            clk_step();
            if (tick_o === 1'b1) ticks++;
            if (tc_o === 1'b1) tcs++;
            checks++;
            if (count_o !== 8'h99) begin errors++; $display("FAIL sat_hold k=%0d got=%h want=99", k, count_o); end
        end
        checks++;
        if (ticks != 3 || tcs != 0) begin
            errors++; $display("FAIL sat_pulses got ticks=%0d tcs=%0d want 3 0", ticks, tcs);
        end
        up = 1'b0;
        repeat (DIV) clk_step();
        checks++;
        if (count_o !== 8'h98 || tc_o !== 1'b0) begin
            errors++; $display("FAIL sat_leave got count=%h tc=%b want 98 0", count_o, tc_o);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        test_reset();
        test_up_count();
        test_down_count();
        test_load_collision();
        test_enable_hold();
`ifdef UPDOWN_TIMER_SATURATE_EN
        test_saturate();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_timer_gen.md
Name: updown_timer_gen

Overview:
Parametrised multi-digit up/down timer, successor to the fixed-configuration lab timer.
- Divides the system clock down to a tick rate and counts ticks in a chain of DIGITS digits, each of radix DIGIT_MOD.
- Supports synchronous load, enable and direction control, and emits a terminal-count pulse.
- Drives active-low 7-segment outputs for every digit.
- Sits between board switches/buttons and the HEX displays; also usable as a generic event timer.

Parameters:
- CLK_HZ, 50000000: input clock frequency.
- TICK_HZ, 1000: count rate. DIV = CLK_HZ/TICK_HZ. DIV >= 1 and must be an integer.
- DIGITS, 5: number of digits, 1..8.
- DIGIT_MOD, 10: radix of every digit, 2..16. Each digit is 4 bits wide.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: count enable, active-high, sampled on clk.
- up, input, 1: direction. 1 = increment, 0 = decrement.
- load, input, 1: synchronous load strobe, active-high.
- load_val, input, 4*DIGITS: load value, digit 0 in [3:0].
- count_o, output, 4*DIGITS: current digit values, digit 0 in [3:0].
- seg_o, output, 7*DIGITS: active-low segments {g,f,e,d,c,b,a} per digit, digit 0 in [6:0].
- tick_o, output, 1: one-cycle pulse on each prescaler rollover.
- tc_o, output, 1: one-cycle pulse when the count wraps.

Behaviour:
- Reset: while rst=1 at a clk edge:
  - prescaler = 0, all digits = 0, tick_o = 0, tc_o = 0.
  - seg_o shows "0" on every digit (7'b1000000 each).
  - rst overrides load and en.
- Priority per edge: rst > load > en.
- Prescaler:
  - Width is clog2(DIV), minimum 1.
  - When en=1 it counts 0..DIV-1. At DIV-1 it returns to 0 and the count step occurs on the same edge; tick_o is high for that one cycle.
  - DIV=1 gives a step on every enabled cycle.
- Load (load=1):
  - Digits take load_val. Any digit >= DIGIT_MOD is clamped to DIGIT_MOD-1.
  - Prescaler resets to 0. No step and no tick_o in that cycle, even if the prescaler was at DIV-1.
  - en is ignored in the load cycle.
- en=0: prescaler and digits hold, tick_o = 0. On re-enable, counting resumes from the held prescaler value; no ticks are lost or added.
- Step, up=1:
  - Digit 0 increments.
  - A digit at DIGIT_MOD-1 goes to 0 and carries into the next digit.
  - All digits at max go to all 0, and tc_o pulses on that same edge.
- Step, up=0:
  - Digit 0 decrements.
  - A digit at 0 goes to DIGIT_MOD-1 and borrows from the next digit.
  - All digits at 0 go to all max, and tc_o pulses.
- up is sampled only on step edges. Changing it between ticks takes effect at the next step.
- Latency:
  - count_o, tick_o and tc_o are registered.
  - seg_o is a combinational decode of the registered digits, so it updates in the same cycle as count_o.
- Segment decode:
  - Values 0-9 use the standard glyphs.
  - Values 10-15 show A, b, C, d, E, F.

Optional Feature:
- Macro: UPDOWN_TIMER_SATURATE_EN.
- Not defined (default): wrap-around as described in Behaviour.
- Defined:
  - Counting saturates at the boundary: all max when up=1, all 0 when up=0.
  - tc_o pulses once on the step that reaches the boundary.
  - Further steps in the same direction leave digits unchanged and produce no tc_o; tick_o still pulses.
  - A step in the opposite direction, or a load, leaves saturation normally.

Test Plan:
All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10), DIGITS=2, DIGIT_MOD=10 unless noted.
1. Reset: rst=1 for 3 clk with load=1, load_val=8'h42 -> count_o=8'h00, seg_o=14'h2040, tick_o=0, tc_o=0.
2. Up count: en=1, up=1 from 00 -> tick_o every 10 clk; 09 -> 10 with carry; 99 -> 00 with tc_o high for exactly 1 clk; 100 ticks = 1000 clk per full cycle.
3. Down count: load 8'h01, then en=1, up=0 -> 01, 00, 99 with tc_o pulse on the 00->99 edge, then 98.
4. Load collision: assert load with load_val=8'h57 on the cycle where the prescaler is 9 -> count_o=8'h57, no tick_o that cycle, next step to 58 exactly 10 clk later. Separately, load_val=8'h5C -> count_o=8'h59 (clamped).
5. Enable hold: en=0 for 25 clk when the prescaler is at 4 -> count_o frozen, no tick_o; after en=1 the next step occurs 6 clk later.
6. Saturate (macro defined): load 8'h98, en=1, up=1 -> 99 with one tc_o pulse; next 3 ticks hold at 99 with no tc_o; set up=0 -> 98 on the next tick.
